// File: rtl/aes_stream_ctrl_if.sv
// Signal bundle around aes_stream_ctrl: upstream byte stream, AES core load/start/done
// ports, ciphertext byte stream and status. master = controller, slave = its surroundings.
interface aes_stream_ctrl_if;
  // Every valid/ready pair moves one byte on a rising clk edge where both are high.
  // Ready never depends on the same pair's valid. A raised out_valid keeps out_byte and
  // out_last stable until accepted. The core's ld_*_ready must not depend on ld_*_valid,
  // because ld_*_valid follows in_valid combinationally.
  logic         in_valid;
  logic [7:0]   in_byte;
  logic         in_ready;
  logic         ld_key_valid;
  logic [7:0]   ld_key_byte;
  logic         ld_key_ready;
  logic         ld_state_valid;
  logic [7:0]   ld_state_byte;
  logic         ld_state_ready;
  logic         start;
  logic [127:0] core_state_out;
  logic         core_done;
  logic         out_valid;
  logic [7:0]   out_byte;
  logic         out_last;
  logic         out_ready;
  logic         key_loaded;
  logic         busy;
  logic         err;
  logic [2:0]   dbg_state;

  modport master (
    input  in_valid, in_byte, ld_key_ready, ld_state_ready, core_state_out, core_done,
           out_ready,
    output in_ready, ld_key_valid, ld_key_byte, ld_state_valid, ld_state_byte, start,
           out_valid, out_byte, out_last, key_loaded, busy, err, dbg_state
  );

  modport slave (
    output in_valid, in_byte, ld_key_ready, ld_state_ready, core_state_out, core_done,
           out_ready,
    input  in_ready, ld_key_valid, ld_key_byte, ld_state_valid, ld_state_byte, start,
           out_valid, out_byte, out_last, key_loaded, busy, err, dbg_state
  );
endinterface

// File: rtl/aes_stream_ctrl.sv
// Host-side sequencer for a bytewise-loaded AES-256 core: key once, then 16-byte blocks.
// Define AES_STREAM_OVERLAP_EN to drain ciphertext while the next plaintext loads.
module aes_stream_ctrl #(
  parameter int DONE_TIMEOUT = 2047,
  parameter int TO_W         = 12
) (
  input logic               clk,
  input logic               rst_n,
  aes_stream_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_KEY   = 3'd0,
    S_PT    = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_DRAIN = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t          r_st;
  state_t          w_st_nxt;
  logic [4:0]      r_key_cnt;
  logic [3:0]      r_pt_cnt;
  logic [3:0]      r_out_cnt;
  logic [TO_W-1:0] r_wd;
  logic [127:0]    r_buf;
  logic            r_buf_full;
  logic            r_key_loaded;
  logic            r_err;

  logic            w_pt_room;
  logic            w_key_fire;
  logic            w_pt_fire;
  logic            w_out_valid;
  logic            w_out_fire;
  logic            w_capture;
  logic            w_wd_hit;
  logic            w_wd_expire;
  logic            w_start;

`ifdef AES_STREAM_OVERLAP_EN
  // The drain engine runs independently, so plaintext may load over a full buffer.
  assign w_pt_room = 1'b1;
`else
  assign w_pt_room = !r_buf_full;
`endif

  assign bus.ld_key_byte    = bus.in_byte;
  assign bus.ld_state_byte  = bus.in_byte;
  assign bus.ld_key_valid   = (r_st == S_KEY) && bus.in_valid;
  assign bus.ld_state_valid = (r_st == S_PT) && bus.in_valid && w_pt_room;
  assign bus.in_ready       = ((r_st == S_KEY) && bus.ld_key_ready) ||
                              ((r_st == S_PT) && bus.ld_state_ready && w_pt_room);

  assign w_key_fire  = bus.ld_key_valid && bus.ld_key_ready;
  assign w_pt_fire   = bus.ld_state_valid && bus.ld_state_ready;
  assign w_out_valid = r_buf_full && (r_st != S_ERR);
  assign w_out_fire  = w_out_valid && bus.out_ready;
  assign w_capture   = (r_st == S_WAIT) && bus.core_done;
  assign w_wd_hit    = (r_wd == TO_W'(DONE_TIMEOUT - 1));
  // A done in the expiry cycle still wins over the timeout.
  assign w_wd_expire = (r_st == S_WAIT) && !bus.core_done && w_wd_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_st <= S_KEY;
    else        r_st <= w_st_nxt;
  end

  always_comb begin
    w_st_nxt = r_st;
    w_start  = 1'b0;
    case (r_st)
      S_KEY:   if (w_key_fire && (r_key_cnt == 5'd31)) w_st_nxt = S_PT;
      S_PT:    if (w_pt_fire && (r_pt_cnt == 4'd15)) w_st_nxt = S_START;
      S_START: begin
        // Holding here while ciphertext remains keeps a new done from overwriting it.
        if (!r_buf_full) begin
          w_start  = 1'b1;
          w_st_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.core_done) begin
`ifdef AES_STREAM_OVERLAP_EN
          w_st_nxt = S_PT;
`else
          w_st_nxt = S_DRAIN;
`endif
        end else if (w_wd_hit) begin
          w_st_nxt = S_ERR;
        end
      end
      S_DRAIN: if (w_out_fire && (r_out_cnt == 4'd15)) w_st_nxt = S_PT;
      S_ERR:   w_st_nxt = S_ERR;
      default: w_st_nxt = S_KEY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_cnt    <= '0;
      r_pt_cnt     <= '0;
      r_wd         <= '0;
      r_key_loaded <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      if (w_key_fire) r_key_cnt <= r_key_cnt + 5'd1;
      if (w_key_fire && (r_key_cnt == 5'd31)) r_key_loaded <= 1'b1;
      if (w_pt_fire) r_pt_cnt <= r_pt_cnt + 4'd1;
      if (r_st == S_START) r_wd <= '0;
      else if ((r_st == S_WAIT) && !bus.core_done) r_wd <= r_wd + 1'b1;
      if (w_wd_expire) r_err <= 1'b1;
    end
  end

  // Ciphertext buffer: captured on done, shifted out MSB byte first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_out_cnt  <= '0;
    end else if (w_capture) begin
      r_buf      <= bus.core_state_out;
      r_buf_full <= 1'b1;
      r_out_cnt  <= '0;
    end else if (w_out_fire) begin
      r_buf     <= {r_buf[119:0], 8'h00};
      r_out_cnt <= r_out_cnt + 4'd1;
      if (r_out_cnt == 4'd15) r_buf_full <= 1'b0;
    end
  end

  assign bus.start      = w_start;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_byte   = r_buf[127:120];
  assign bus.out_last   = w_out_valid && (r_out_cnt == 4'd15);
  assign bus.key_loaded = r_key_loaded;
  assign bus.busy       = (r_st != S_PT) || r_buf_full;
  assign bus.err        = r_err;
  assign bus.dbg_state  = r_st;

endmodule
